// File: rtl/ctrl_50mhz.sv
// 50 MHz front end: deserialises framed serial bits, hunts for a header byte and
// pushes the following BYTES_PER_PKT payload bytes into the async FIFO.
module ctrl_50mhz #(
    parameter logic [7:0] HDR_A         = 8'hA5,
    parameter logic [7:0] HDR_B         = 8'hC3,
    parameter int         BYTES_PER_PKT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       data_ena,
    input  logic       serial_data,
    input  logic       fifo_full,
    output logic       wr_fifo,
    output logic [7:0] fifo_data,
    output logic       in_packet,
    output logic       overflow
);

    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_PKT - 1);

    typedef enum logic {
        HDR_SEARCH = 1'b0,
        PAYLOAD    = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt, byte_cnt_nxt;
    logic       byte_done;
    logic [7:0] byte_val;
    logic       pay_done;

    // Only the low 7 bits are kept: the completed byte is formed with the live bit.
    assign byte_done = data_ena && (bit_cnt == 3'd7);
    assign byte_val  = {shift_reg, serial_data};
    assign pay_done  = byte_done && (state == PAYLOAD);
    assign in_packet = (state == PAYLOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (data_ena) begin
            shift_reg <= byte_val[6:0];
            bit_cnt   <= bit_cnt + 3'd1;
        end else begin
            bit_cnt   <= '0;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        case (state)
            HDR_SEARCH: begin
                if (byte_done && (byte_val == HDR_A || byte_val == HDR_B)) begin
                    state_nxt    = PAYLOAD;
                    byte_cnt_nxt = '0;
                end
            end
            PAYLOAD: begin
                if (byte_done) begin
                    byte_cnt_nxt = byte_cnt + 4'd1;
                    if (byte_cnt == LAST_BYTE) state_nxt = HDR_SEARCH;
                end
            end
            default: begin
                state_nxt    = HDR_SEARCH;
                byte_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HDR_SEARCH;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Dropped bytes still advance byte_cnt so packet framing is preserved.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_fifo   <= 1'b0;
            overflow  <= 1'b0;
            fifo_data <= '0;
        end else begin
            wr_fifo  <= pay_done && !fifo_full;
            overflow <= pay_done && fifo_full;
            if (pay_done) fifo_data <= byte_val;
        end
    end

endmodule
